// File: rtl/mem_io_slave_pkg.sv
// rtl/mem_io_slave_pkg.sv - shared states, channel offsets and STATUS layout for mem_io_slave
package mem_io_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_RD_WAIT = 2'd1;
  localparam state_t ST_IO_WAIT = 2'd2;
  localparam state_t ST_ACK     = 2'd3;

  localparam logic [3:0] OFF_TXDATA = 4'h0;
  localparam logic [3:0] OFF_STATUS = 4'h4;
  localparam int         CH_STRIDE  = 16;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_CNT_LSB = 2;
  localparam int STAT_OVF_LSB = 8;

  function automatic logic [31:0] status_word(input logic [7:0] ovf, input logic [5:0] cnt,
                                              input logic full, input logic empty);
    logic [31:0] w;
    w = '0;
    w[STAT_OVF_LSB +: 8] = ovf;
    w[STAT_CNT_LSB +: 6] = cnt;
    w[STAT_FULL]         = full;
    w[STAT_EMPTY]        = empty;
    return w;
  endfunction

endpackage

// File: rtl/mem_io_slave_if.sv
// rtl/mem_io_slave_if.sv - PicoRV32 native memory bus bundle
interface mem_io_slave_if;
  logic        mem_valid;
  logic        mem_instr;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_ready;
  logic [31:0] mem_rdata;

  modport master (output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                  input  mem_ready, mem_rdata);
  modport slave  (input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
                  output mem_ready, mem_rdata);
endinterface

// File: rtl/mem_io_slave_byte_fifo.sv
// rtl/mem_io_slave_byte_fifo.sv - byte FIFO feeding one output channel
module byte_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic [7:0]                 push_data,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          do_push, do_pop;

  // A simultaneous pop frees the slot, so a push into a full FIFO is legal then.
  always_comb begin
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != FULL_CNT) || do_pop);
    wr_d    = wr_q + {{(AW-1){1'b0}}, do_push};
    rd_d    = rd_q + {{(AW-1){1'b0}}, do_pop};
    cnt_d   = cnt_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_q] <= push_data;
  end

  assign full  = (cnt_q == FULL_CNT);
  assign empty = (cnt_q == '0);
  assign count = cnt_q;
  assign head  = (cnt_q == '0) ? 8'h00 : mem_q[rd_q];

endmodule

// File: rtl/mem_io_slave.sv
// rtl/mem_io_slave.sv - word RAM plus NUM_CH buffered byte channels on the PicoRV32 bus
// MEM_IO_OVERFLOW_DROP_EN: drop and count writes to a full channel instead of stalling.
module mem_io_slave
  import mem_io_pkg::*;
#(
  parameter int          MEM_WORDS  = 4096,
  parameter int          NUM_CH     = 4,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] IO_BASE    = 32'h1000_0000,
  parameter int          READ_WAIT  = 0
) (
  input  logic                  clk,
  input  logic                  reset,
  mem_io_slave_if.slave         bus,
  output logic [8*NUM_CH-1:0]   out_data,
  output logic [NUM_CH-1:0]     out_valid,
  input  logic [NUM_CH-1:0]     out_ready,
  output logic                  bus_err
);
  localparam int RAM_AW = $clog2(MEM_WORDS);
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]       ram_q [MEM_WORDS];
  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [7:0]        wbyte_q, wbyte_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [NUM_CH-1:0] push, full, empty;
  logic [7:0]        push_data;
  logic [CW-1:0]     count [NUM_CH];
  logic [7:0]        ovf [NUM_CH];
  logic [3:0]        ram_we;

  logic [31:0]       io_rel;
  logic              is_ram, is_io, is_tx, is_stat, is_wr;
  logic [CH_W-1:0]   ch;
  logic [RAM_AW-1:0] widx;

`ifdef MEM_IO_OVERFLOW_DROP_EN
  logic [NUM_CH-1:0] ovf_inc;
  logic [7:0]        ovf_q [NUM_CH];
  logic [7:0]        ovf_d [NUM_CH];
`endif

  always_comb begin
    io_rel  = bus.mem_addr - IO_BASE;
    is_ram  = bus.mem_addr < 32'(4*MEM_WORDS);
    is_io   = (bus.mem_addr >= IO_BASE) && (io_rel < 32'(CH_STRIDE*NUM_CH));
    is_tx   = is_io && (io_rel[3:0] == OFF_TXDATA);
    is_stat = is_io && (io_rel[3:0] == OFF_STATUS);
    is_wr   = |bus.mem_wstrb;
    ch      = io_rel[4 +: CH_W];
    widx    = bus.mem_addr[2 +: RAM_AW];
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    wbyte_d   = wbyte_q;
    rdata_d   = rdata_q;
    err_d     = err_q;
    push      = '0;
    push_data = bus.mem_wdata[7:0];
    ram_we    = '0;
`ifdef MEM_IO_OVERFLOW_DROP_EN
    ovf_inc   = '0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.mem_valid) begin
          ch_d    = ch;
          wbyte_d = bus.mem_wdata[7:0];
          rdata_d = '0;
          err_d   = 1'b0;
          state_d = ST_ACK;
          if (is_ram) begin
            if (is_wr) ram_we = bus.mem_wstrb;
            else begin
              rdata_d = ram_q[widx];
              if (READ_WAIT != 0) state_d = ST_RD_WAIT;
            end
          end else if (is_tx) begin
            if (is_wr && !full[ch]) push[ch] = 1'b1;
            else if (is_wr) begin
`ifdef MEM_IO_OVERFLOW_DROP_EN
              ovf_inc[ch] = 1'b1;
`else
              state_d = ST_IO_WAIT;
`endif
            end
          end else if (is_stat) begin
            if (!is_wr) rdata_d = status_word(ovf[ch], 6'(count[ch]), full[ch], empty[ch]);
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_RD_WAIT: state_d = ST_ACK;
      ST_IO_WAIT: begin
        push_data = wbyte_q;
        if (!full[ch_q]) begin
          push[ch_q] = 1'b1;
          state_d    = ST_ACK;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      ch_q    <= '0;
      wbyte_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      wbyte_q <= wbyte_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // RAM is never reset; the guard keeps a write from landing on the edge reset rises.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_we[b] && !reset) ram_q[widx][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
    end
  end

`ifdef MEM_IO_OVERFLOW_DROP_EN
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      ovf_d[c] = (ovf_inc[c] && ovf_q[c] != 8'hFF) ? ovf_q[c] + 8'd1 : ovf_q[c];
      ovf[c]   = ovf_q[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    for (int c = 0; c < NUM_CH; c++) begin
      if (reset) ovf_q[c] <= '0;
      else       ovf_q[c] <= ovf_d[c];
    end
  end
`else
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) ovf[c] = '0;
  end
`endif

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push[c]),
      .push_data (push_data),
      .pop       (out_ready[c]),
      .head      (out_data[8*c +: 8]),
      .full      (full[c]),
      .empty     (empty[c]),
      .count     (count[c])
    );
    assign out_valid[c] = ~empty[c];
  end

  assign bus.mem_ready = (state_q == ST_ACK);
  assign bus.mem_rdata = (state_q == ST_ACK) ? rdata_q : 32'h0;
  assign bus_err       = (state_q == ST_ACK) && err_q;

  logic unused_ok;
  assign unused_ok = ^{bus.mem_instr, bus.mem_addr[1:0], io_rel};

endmodule

// File: tb/tb_mem_io_slave.sv
// tb/tb_mem_io_slave.sv - directed self-checking bench for mem_io_slave
module tb_mem_io_slave;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] out_data;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        bus_err;
  logic        mon_en;
  logic [7:0]  got [$];
  int          n_checks = 0;
  int          n_fail = 0;

`ifdef MEM_IO_OVERFLOW_DROP_EN
  localparam logic [31:0] CH1_AFTER = 32'h0000_0101;
`else
  localparam logic [31:0] CH1_AFTER = 32'h0000_0001;
`endif

  mem_io_slave_if bus();

  mem_io_slave #(
    .MEM_WORDS(4096), .NUM_CH(4), .FIFO_DEPTH(8), .IO_BASE(32'h1000_0000), .READ_WAIT(0)
  ) dut (
    .clk(clk), .reset(reset), .bus(bus),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en && out_valid[0] && out_ready[0]) got.push_back(out_data[7:0]);
  end

  task automatic do_req(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        output logic [31:0] rd, output logic err, output int lat);
    bus.mem_valid = 1'b1; bus.mem_addr = a; bus.mem_wdata = d; bus.mem_wstrb = s;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    lat = 1;
    while (bus.mem_ready !== 1'b1 && lat < 20) begin @(posedge clk); #1; lat++; end
    rd  = bus.mem_rdata;
    err = bus_err;
    if (bus.mem_ready === 1'b1) begin @(posedge clk); #1; end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_checks++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", bus.mem_ready); end
    n_checks++; if (bus.mem_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h want 0", bus.mem_rdata); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b want 0", bus_err); end
    n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    n_checks++; if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_data: got %h want 0", out_data); end
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_ram();
    logic [31:0] rd; logic err; int lat;
    do_req(32'h10, 32'h1122_3344, 4'hF, rd, err, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ram_wr_lat: got %0d want 1", lat); end
    do_req(32'h10, 32'hDEAD_BEEF, 4'b0011, rd, err, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ram_wstrb_lat: got %0d want 1", lat); end
    do_req(32'h10, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h1122_BEEF) begin n_fail++; $display("FAIL ram_rd_data: got %h want 1122beef", rd); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ram_rd_lat: got %0d want 1", lat); end
    do_req(32'h3FFC, 32'hA5A5_5A5A, 4'hF, rd, err, lat);
    do_req(32'h3FFC, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'hA5A5_5A5A) begin n_fail++; $display("FAIL ram_top_word: got %h want a5a55a5a", rd); end
    do_req(32'h4000, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if ({err, rd} !== {1'b1, 32'h0}) begin n_fail++; $display("FAIL ram_past_end: got err=%b rd=%h want err=1 rd=0", err, rd); end
  endtask

  task automatic test_fill();
    logic [31:0] rd; logic err; int lat;
    out_ready = 4'h0;
    for (int i = 0; i < 8; i++) begin
      do_req(32'h1000_0010, 32'hFFFF_FF00 | (32'h41 + i), 4'hF, rd, err, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL fill_lat[%0d]: got %0d want 1", i, lat); end
    end
    do_req(32'h1000_0014, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h22) begin n_fail++; $display("FAIL fill_status_ch1: got %h want 22", rd); end
    do_req(32'h1000_0004, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h01) begin n_fail++; $display("FAIL fill_status_ch0: got %h want 01", rd); end
    n_checks++; if (out_valid !== 4'b0010) begin n_fail++; $display("FAIL fill_valid: got %b want 0010", out_valid); end
    n_checks++; if (out_data[15:8] !== 8'h41) begin n_fail++; $display("FAIL fill_head: got %h want 41", out_data[15:8]); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd; logic err; int lat; logic [7:0] first;
`ifdef MEM_IO_OVERFLOW_DROP_EN
    do_req(32'h1000_0010, 32'h49, 4'hF, rd, err, lat);
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL ovf_drop_lat: got %0d want 1", lat); end
    do_req(32'h1000_0014, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h0122) begin n_fail++; $display("FAIL ovf_status: got %h want 0122", rd); end
    first = 8'h41;
`else
    logic early;
    early = 1'b0;
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h1000_0010; bus.mem_wdata = 32'h49; bus.mem_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    repeat (5) begin if (bus.mem_ready !== 1'b0) early = 1'b1; @(posedge clk); #1; end
    n_checks++; if (early !== 1'b0) begin n_fail++; $display("FAIL stall_no_ready: got ready during stall want none"); end
    out_ready = 4'b0010;
    @(posedge clk); #1;
    out_ready = 4'h0;
    lat = 0;
    while (bus.mem_ready !== 1'b1 && lat < 10) begin @(posedge clk); #1; lat++; end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL stall_release_lat: got %0d want 1", lat); end
    @(posedge clk); #1;
    first = 8'h42;
`endif
    n_checks++; if (out_data[15:8] !== first) begin n_fail++; $display("FAIL ovf_head: got %h want %h", out_data[15:8], first); end
    out_ready = 4'b0010;
    for (int i = 0; i < 8; i++) begin
      n_checks++;
      if ({out_valid[1], out_data[15:8]} !== {1'b1, first + 8'(i)}) begin
        n_fail++; $display("FAIL drain[%0d]: got v=%b d=%h want v=1 d=%h", i, out_valid[1], out_data[15:8], first + 8'(i));
      end
      @(posedge clk); #1;
    end
    out_ready = 4'h0;
    n_checks++; if (out_valid[1] !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b want 0", out_valid[1]); end
  endtask

  task automatic test_unmapped();
    logic [31:0] rd; logic err; int lat;
    do_req(32'h2000_0000, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL unmap_rdata: got %h want 0", rd); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL unmap_err: got %b want 1", err); end
    n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL unmap_lat: got %0d want 1", lat); end
    n_checks++; if (bus_err !== 1'b0) begin n_fail++; $display("FAIL unmap_pulse: got %b want 0 after ack", bus_err); end
    do_req(32'h1000_0018, 32'h55, 4'hF, rd, err, lat);
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL unmap_ch_off8: got %b want 1", err); end
    do_req(32'h1000_0014, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== CH1_AFTER) begin n_fail++; $display("FAIL unmap_fifo: got %h want %h", rd, CH1_AFTER); end
    do_req(32'h10, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h1122_BEEF) begin n_fail++; $display("FAIL unmap_ram: got %h want 1122beef", rd); end
    n_checks++; if (out_valid !== 4'h0) begin n_fail++; $display("FAIL unmap_valid: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; logic err; int lat;
    out_ready = 4'b0001;
    got.delete();
    mon_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      do_req(32'h1000_0000, 32'h61 + i, 4'hF, rd, err, lat);
      n_checks++; if (lat !== 1) begin n_fail++; $display("FAIL b2b_lat[%0d]: got %0d want 1", i, lat); end
      do_req(32'h1000_0004, 32'h0, 4'h0, rd, err, lat);
      n_checks++; if (rd !== 32'h01) begin n_fail++; $display("FAIL b2b_status[%0d]: got %h want 01", i, rd); end
    end
    mon_en = 1'b0;
    out_ready = 4'h0;
    n_checks++; if (got.size() !== 6) begin n_fail++; $display("FAIL b2b_count: got %0d want 6", got.size()); end
    for (int i = 0; i < got.size() && i < 6; i++) begin
      n_checks++; if (got[i] !== 8'h61 + 8'(i)) begin n_fail++; $display("FAIL b2b_order[%0d]: got %h want %h", i, got[i], 8'h61 + 8'(i)); end
    end
  endtask

  task automatic test_reset_in_wait();
    logic [31:0] rd; logic err; int lat; logic bad;
    out_ready = 4'h0;
    for (int i = 0; i < 8; i++) do_req(32'h1000_0020, 32'h80 + i, 4'hF, rd, err, lat);
`ifdef MEM_IO_OVERFLOW_DROP_EN
    do_req(32'h1000_0020, 32'h99, 4'hF, rd, err, lat);
`else
    bus.mem_valid = 1'b1; bus.mem_addr = 32'h1000_0020; bus.mem_wdata = 32'h99; bus.mem_wstrb = 4'hF;
    @(posedge clk); #1;
    bus.mem_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    n_checks++; if (bus.mem_ready !== 1'b0) begin n_fail++; $display("FAIL rst_wait_stalled: got %b want 0", bus.mem_ready); end
`endif
    reset = 1'b1;
    #1;
    n_checks++; if ({bus.mem_ready, out_valid} !== 5'b0) begin n_fail++; $display("FAIL rst_wait_async: got ready=%b valid=%b want 0", bus.mem_ready, out_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 1'b0;
    repeat (6) begin
      if ({bus.mem_ready, out_valid} !== 5'b0) bad = 1'b1;
      @(posedge clk); #1;
    end
    n_checks++; if (bad !== 1'b0) begin n_fail++; $display("FAIL rst_wait_no_push: got activity after reset want none"); end
    do_req(32'h1000_0024, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h01) begin n_fail++; $display("FAIL rst_wait_status: got %h want 01", rd); end
    do_req(32'h10, 32'h0, 4'h0, rd, err, lat);
    n_checks++; if (rd !== 32'h1122_BEEF) begin n_fail++; $display("FAIL rst_ram_kept: got %h want 1122beef", rd); end
  endtask

  initial begin
    bus.mem_valid = 1'b0; bus.mem_instr = 1'b0; bus.mem_addr = '0; bus.mem_wdata = '0; bus.mem_wstrb = '0;
    out_ready = 4'h0;
    mon_en = 1'b0;
    test_reset();
    test_ram();
    test_fill();
    test_overflow();
    test_unmapped();
    test_back_to_back();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t want finished", $time);
    $fatal(1);
  end

endmodule
